// File: rtl/clock_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// master drives enables and divisor loads; slave is the divider itself.
interface clock_divider_prog_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 16
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0] enable;
   logic                load;
   logic [SEL_W-1:0]    load_sel;
   logic [WIDTH-1:0]    div_in;
   logic [CHANNELS-1:0] clk_out;
   logic [CHANNELS-1:0] tick;
   logic [CHANNELS-1:0] pending;

   modport master (
      output enable, load, load_sel, div_in,
      input  clk_out, tick, pending
   );

   modport slave (
      input  enable, load, load_sel, div_in,
      output clk_out, tick, pending
   );
endinterface

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable clock/tick generator.
// Divisor changes are applied only on period boundaries (hitless).
module clock_divider_prog #(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 64
) (
   input logic                 clk_in,
   input logic                 reset,
   clock_divider_prog_if.slave bus
);
   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic             load_ok;
   logic [WIDTH-1:0] load_val;

   // Out-of-range selects are dropped; divisors below 2 are clamped.
   assign load_ok  = bus.load && (int'(bus.load_sel) < CHANNELS);
   assign load_val = (bus.div_in < MIN_DIV) ? MIN_DIV : bus.div_in;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] count;
      logic [WIDTH-1:0] div_active;
      logic [WIDTH-1:0] div_pend;
      logic [WIDTH-1:0] half;
      logic             pend_q;
      logic             running;
      logic             clk_q;
      logic             tick_q;
      logic             en;
      logic             hit;
      logic             wrap;

      assign en   = bus.enable[i];
      assign hit  = load_ok && (int'(bus.load_sel) == i);
      assign half = div_active >> 1;
      assign wrap = en && (!running || (count == div_active - ONE));

      always_ff @(posedge clk_in or posedge reset) begin
         if (reset) begin
            count      <= '0;
            div_active <= DEF_DIV;
            div_pend   <= DEF_DIV;
            pend_q     <= 1'b0;
            running    <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
         end else begin
            running <= en;
            if (en && wrap) begin
               count  <= '0;
               clk_q  <= 1'b1;
               tick_q <= 1'b1;
               pend_q <= 1'b0;
               if (hit)
                  div_active <= load_val;
               else if (pend_q)
                  div_active <= div_pend;
            end else if (en) begin
               count  <= count + ONE;
               clk_q  <= (count + ONE) < half;
               tick_q <= 1'b0;
               if (hit) begin
                  div_pend <= load_val;
                  pend_q   <= 1'b1;
               end
            end else begin
               count  <= '0;
               clk_q  <= 1'b0;
               tick_q <= 1'b0;
               // Idle channel takes the new divisor at once, superseding any queued one.
               if (hit) begin
                  div_active <= load_val;
                  pend_q     <= 1'b0;
               end
            end
         end
      end

      assign bus.clk_out[i] = clk_q;
      assign bus.tick[i]    = tick_q;
      assign bus.pending[i] = pend_q;
   end
endmodule

// File: tb/tb_clock_divider_prog.sv
// Scoreboard bench for clock_divider_prog: expected per-cycle
// output vectors are queued with the stimulus and popped after each edge.
module tb_clock_divider_prog;
   localparam int CH = 3;
   localparam int W  = 16;

   typedef struct packed {
      logic [CH-1:0] c;
      logic [CH-1:0] t;
      logic [CH-1:0] p;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t e;

   clock_divider_prog_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

   clock_divider_prog #(
      .CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(64)
   ) dut (
      .clk_in(clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic void push(logic [CH-1:0] c, logic [CH-1:0] t,
                                logic [CH-1:0] p);
      exp_t x;
      x.c = c;
      x.t = t;
      x.p = p;
      q.push_back(x);
   endfunction

   function automatic void push_wave(int ch, int div, int np);
      logic [CH-1:0] c, t;
      for (int n = 0; n < np; n++)
         for (int k = 0; k < div; k++) begin
            c = '0;
            t = '0;
            c[ch] = (k < div / 2);
            t[ch] = (k == 0);
            push(c, t, '0);
         end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.enable = '0;
      bus.load = 1'b0;
      bus.load_sel = '0;
      bus.div_in = '0;
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.clk_out !== 3'b000) begin
         errors++;
         $display("FAIL reset_clk got=%b want=000", bus.clk_out);
      end
      checks++;
      if (bus.tick !== 3'b000) begin
         errors++;
         $display("FAIL reset_tick got=%b want=000", bus.tick);
      end
      checks++;
      if (bus.pending !== 3'b000) begin
         errors++;
         $display("FAIL reset_pend got=%b want=000", bus.pending);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_default();
      bus.enable = 3'b001;
      push_wave(0, 64, 2);
      while (q.size() > 0) begin
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL default c/t/p got=%b/%b/%b want=%b/%b/%b",
                     bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
   endtask

   task automatic test_disabled_load();
      bus.enable = '0;
      push('0, '0, '0);
      push('0, '0, '0);
      push_wave(1, 5, 3);
      for (int i = 0; q.size() > 0; i++) begin
         bus.load = (i == 1);
         bus.load_sel = 2'd1;
         bus.div_in = 16'd5;
         bus.enable = (i >= 2) ? 3'b010 : 3'b000;
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL disabled_load i=%0d got=%b/%b/%b want=%b/%b/%b",
                     i, bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_hitless();
      push('0, '0, '0);
      push('0, '0, '0);
      for (int k = 0; k < 8; k++)
         push({2'b0, k < 4}, {2'b0, k == 0}, {2'b0, k >= 3});
      push_wave(0, 4, 3);
      for (int i = 0; q.size() > 0; i++) begin
         bus.enable = (i >= 2) ? 3'b001 : 3'b000;
         bus.load = (i == 1) || (i == 5);
         bus.load_sel = 2'd0;
         bus.div_in = (i == 1) ? 16'd8 : 16'd4;
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL hitless i=%0d got=%b/%b/%b want=%b/%b/%b",
                     i, bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_min_div();
      for (int pass = 0; pass < 2; pass++) begin
         push('0, '0, '0);
         push('0, '0, '0);
         push_wave(0, 2, 6);
         for (int i = 0; q.size() > 0; i++) begin
            bus.enable = (i >= 2) ? 3'b001 : 3'b000;
            bus.load = (i == 1) || (i == 8);
            // Second load targets a nonexistent channel and must be dropped.
            bus.load_sel = (i == 8) ? 2'd3 : 2'd0;
            bus.div_in = (i == 8) ? 16'd8 : 16'(pass);
            step();
            e = q.pop_front();
            checks++;
            if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
               errors++;
               $display("FAIL min_div pass=%0d i=%0d got=%b/%b/%b want=%b/%b/%b",
                        pass, i, bus.clk_out, bus.tick, bus.pending,
                        e.c, e.t, e.p);
            end
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_disable_reenable();
      logic [8:0] en_seq;
      logic [8:0] c_seq;
      logic [8:0] t_seq;
      en_seq = 9'b100110011;
      c_seq  = 9'b100110011;
      t_seq  = 9'b100010001;
      push('0, '0, '0);
      push('0, '0, '0);
      for (int k = 0; k < 9; k++)
         push({2'b0, c_seq[k]}, {2'b0, t_seq[k]}, '0);
      for (int i = 0; q.size() > 0; i++) begin
         bus.load = (i == 1);
         bus.load_sel = 2'd0;
         bus.div_in = 16'd4;
         bus.enable = (i >= 2) ? {2'b0, en_seq[i-2]} : 3'b000;
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL disable_reenable i=%0d got=%b/%b/%b want=%b/%b/%b",
                     i, bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_reset_pending();
      push('0, '0, '0);
      push(3'b001, 3'b001, 3'b000);
      push(3'b001, 3'b000, 3'b001);
      for (int i = 0; q.size() > 0; i++) begin
         bus.enable = (i >= 1) ? 3'b001 : 3'b000;
         bus.load = (i == 2);
         bus.load_sel = 2'd0;
         bus.div_in = 16'd6;
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL pre_reset i=%0d got=%b/%b/%b want=%b/%b/%b",
                     i, bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
      bus.load = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.clk_out, bus.tick, bus.pending} !== 9'b0) begin
         errors++;
         $display("FAIL async_reset got=%b/%b/%b want=000/000/000",
                  bus.clk_out, bus.tick, bus.pending);
      end
      bus.enable = '0;
      step();
      rst = 1'b0;
      step();
      push_wave(0, 64, 1);
      push_wave(0, 64, 1);
      bus.enable = 3'b001;
      while (q.size() > 0) begin
         step();
         e = q.pop_front();
         checks++;
         if ({bus.clk_out, bus.tick, bus.pending} !== {e.c, e.t, e.p}) begin
            errors++;
            $display("FAIL post_reset_div got=%b/%b/%b want=%b/%b/%b",
                     bus.clk_out, bus.tick, bus.pending, e.c, e.t, e.p);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_disabled_load();
      test_hitless();
      test_min_div();
      test_disable_reenable();
      test_reset_pending();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/clock_divider_prog.md
# clock_divider_prog

Multi-channel programmable clock/tick generator. It produces CHANNELS independent divided clock outputs from the single system clock, each with a runtime-loadable divisor, a per-channel enable, and a one-cycle tick strobe at the start of every output period. Divisor changes are hitless: they take effect only on a period boundary. Sits beside the system clock source and feeds slow-rate logic such as display scan, debouncers and LED blink timers. All outputs are flop-driven; none are combinational.

## Interface
- CHANNELS, 4, number of independent divider channels (>=1)
- WIDTH, 16, divisor and counter width in bits (>=2)
- DEFAULT_DIV, 64, per-channel divisor after reset (2 .. 2^WIDTH-1)
- clk_in  input  1  system clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- enable  input  CHANNELS  per-channel run enable, level-sensitive
- load  input  1  one-cycle divisor-load strobe
- load_sel  input  max(1,$clog2(CHANNELS))  target channel for load
- div_in  input  WIDTH  divisor value captured on load
- clk_out  output  CHANNELS  divided clock per channel
- tick  output  CHANNELS  one-cycle pulse coinciding with each clk_out rising cycle
- pending  output  CHANNELS  high while a loaded divisor awaits its period boundary

## Operation
- Per-channel registers: count[WIDTH], div_active[WIDTH], div_pend[WIDTH], pending, running, clk_out, tick.
- Reset (async): count=0, div_active=div_pend=DEFAULT_DIV, pending=0, running=0, clk_out=0, tick=0 on all channels.
- running <= enable[i] every cycle (it is the registered enable).
- half = div_active >> 1.
- Wrap event W = enable[i] && (!running || count == div_active-1).
- On each clock edge with enable[i] high:
  - If W: count<=0, clk_out<=1, tick<=1. If pending, div_active<=div_pend and pending<=0.
  - Otherwise: count<=count+1, clk_out<=(count+1 < half), tick<=0.
- On each clock edge with enable[i] low: count<=0, clk_out<=0, tick<=0. The clock stops low within one cycle.
- Load: when load=1 and load_sel<CHANNELS, the value v = (div_in<2 ? 2 : div_in) goes to channel load_sel.
  - Channel disabled (enable low): div_active<=v directly; pending stays 0.
  - Channel enabled, no W this cycle: div_pend<=v, pending<=1.
  - Channel enabled, W this cycle: the load bypasses the pending path, so div_active<=v at this wrap and pending<=0.
  - Repeated loads before a wrap: the last one wins.
  - load_sel>=CHANNELS: the load is ignored.
- Period of clk_out is div_active cycles: high for half cycles, low for div_active-half cycles. Odd divisors give the shorter high phase.
- The count register must never exceed div_active-1 after a divisor change. This holds because changes apply only when count is reset to 0.

## Timing
- Enable rises, sampled at edge k: clk_out=1 and tick=1 are visible after edge k (first period starts immediately).
- div=4 waveform: clk_out 1,1,0,0 repeating; tick 1,0,0,0.
- div=5 waveform: clk_out 1,1,0,0,0; tick 1,0,0,0,0.
- div=2 waveform: clk_out 1,0; tick 1,0.
- Enable falls, sampled at edge k: clk_out=0 and tick=0 after edge k, regardless of phase.
- Load-to-effect latency: at most one full current period, plus zero extra cycles. pending rises the edge after load and falls at the applying wrap edge.
- Channels are fully independent; simultaneous wraps or loads on other channels have no interaction.
- Reset asserted mid-period: all outputs go to reset values immediately (asynchronously), and any pending load is discarded.

## Test plan
- Reset, then enable[0]=1 with default 64 -> clk_out[0] high 32 cycles, low 32; tick[0] once every 64 cycles; the other channels remain 0.
- Disabled channel 1, load div_in=5 -> pending[1] stays 0. Then enable -> pattern 1,1,0,0,0 with a tick on every 5th cycle.
- Channel 0 running at div 8, load div_in=4 at count=2 -> pending[0]=1 until the next wrap. Periods seen: 8, then 4,4,...; no runt pulse.
- Load div_in=0 and div_in=1 -> both treated as 2 (clk_out toggles every cycle). Load with load_sel=CHANNELS -> no register change.
- Disable channel mid-high-phase -> clk_out 0 the next cycle. Re-enable -> tick and clk_out=1 on the first enabled edge.
- Assert reset mid-period with a pending load -> all outputs 0 at once. After release and enable, the divisor is DEFAULT_DIV, not the pending value.
